mem_line_arbiter: RTL

- N-channel arbiter that lets several line-based cache memory ports share one slow-memory port.
- Sits between the caches' mem_* ports (I-cache, D-cache, future L2/prefetch) and a single 128-bit slow memory.
- Generalises the one-memory-per-cache top-level arrangement to N_CH channels.
- Uses a registered round-robin grant and a one-transaction-at-a-time handshake.

---
 rtl/mem_line_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one slow line-memory port among N_CH cache channels, one transaction at a time.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_line_arbiter #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic                     clk,
  input  logic                     proc_reset,
  input  logic [N_CH-1:0]          ch_read,
  input  logic [N_CH-1:0]          ch_write,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [N_CH-1:0]          ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);
  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t              r_state, w_state;
  logic [GW-1:0]       r_grant, w_grant, r_rr, w_rr, w_win;
  logic                w_found;
  logic [N_CH-1:0]     w_req, r_ch_ready, w_ch_ready;
  logic                r_mem_read, w_mem_read, r_mem_write, w_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
  logic [LINE_W-1:0]   r_mem_wdata, w_mem_wdata, r_ch_rdata, w_ch_rdata;
  assign w_req = ch_read | ch_write;
  // Scan from farthest to nearest candidate so the nearest requester is the last one written.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = N_CH - 1; i >= 0; i--)
      if (w_req[i]) begin
        w_win   = GW'(i);
        w_found = 1'b1;
      end
`else
    for (int k = N_CH; k >= 1; k--)
      if (w_req[GW'((int'(r_rr) + k) % N_CH)]) begin
        w_win   = GW'((int'(r_rr) + k) % N_CH);
        w_found = 1'b1;
      end
`endif
  end
  always_comb begin
    w_state     = r_state;
    w_grant     = r_grant;
    w_rr        = r_rr;
    w_mem_read  = r_mem_read;
    w_mem_write = r_mem_write;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_ch_rdata  = r_ch_rdata;
    w_ch_ready  = '0;
    case (r_state)
      IDLE: if (w_found) begin
        w_state     = ISSUE;
        w_grant     = w_win;
`ifndef ARB_FIXED_PRIO_EN
        w_rr        = w_win;
`endif
        w_mem_addr  = ch_addr[int'(w_win)*ADDR_W +: ADDR_W];
        w_mem_wdata = ch_wdata[int'(w_win)*LINE_W +: LINE_W];
        w_mem_write = ch_write[w_win];
        w_mem_read  = ch_read[w_win] & ~ch_write[w_win];
      end
      ISSUE: if (mem_ready) begin
        w_state             = RESP;
        w_ch_rdata          = mem_rdata;
        w_ch_ready[r_grant] = 1'b1;
        w_mem_read          = 1'b0;
        w_mem_write         = 1'b0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr        <= GW'(N_CH - 1);
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ch_rdata  <= '0;
      r_ch_ready  <= '0;
    end else begin
      r_state     <= w_state;
      r_grant     <= w_grant;
      r_rr        <= w_rr;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_ch_rdata  <= w_ch_rdata;
      r_ch_ready  <= w_ch_ready;
    end
  end
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ch_rdata  = r_ch_rdata;
  assign ch_ready  = r_ch_ready;
endmodule
